// File: rtl/calc_mem_bank.sv
// calc_mem_bank: operand/result store with ADD/SUB accumulate and clear sweep; define CALC_MEM_SAT_EN to saturate ADD/SUB
module calc_mem_bank #(
  parameter int WIDTH = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WIDTH-1:0]  cmd_wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              ovf,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_READ = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_acc, w_arith, w_read, w_sweep, w_we, w_ovf;
  logic [WIDTH-1:0]  w_old, w_res, w_wdata;
  logic [WIDTH:0]    w_sum;
  logic [ADDR_W-1:0] w_waddr;
  always_comb begin
    cmd_ready = r_state == ST_IDLE;
    busy = !cmd_ready;
    w_acc = cmd_valid && cmd_ready && !rst;
    w_arith = w_acc && (cmd_op == OP_ADD || cmd_op == OP_SUB);
    w_read = w_acc && cmd_op == OP_READ;
    w_sweep = r_state == ST_CLEAR && !rst;
    w_old = r_mem[cmd_addr];
    // one extra sign bit makes overflow a simple disagreement of the top two bits
    w_sum = cmd_op == OP_SUB ? {w_old[WIDTH-1], w_old} - {cmd_wdata[WIDTH-1], cmd_wdata}
                             : {w_old[WIDTH-1], w_old} + {cmd_wdata[WIDTH-1], cmd_wdata};
    w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
`ifdef CALC_MEM_SAT_EN
    w_res = !w_ovf ? w_sum[WIDTH-1:0]
          : w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    w_res = w_sum[WIDTH-1:0];
`endif
    w_we = w_sweep || w_arith || (w_acc && cmd_op == OP_WRITE);
    w_waddr = w_sweep ? r_clr_idx : cmd_addr;
    w_wdata = w_sweep ? '0 : w_arith ? w_res : cmd_wdata;
  end
  always_ff @(posedge clk)
    if (w_we) r_mem[w_waddr] <= w_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_clr_idx <= '0;
      rdata <= '0;
      rvalid <= 1'b0;
      ovf <= 1'b0;
    end else begin
      rvalid <= w_arith || w_read;
      if (w_arith) begin
        rdata <= w_res;
        ovf <= w_ovf;
      end else if (w_read) rdata <= w_old;
      if (w_acc && cmd_op == OP_CLR) begin
        r_state <= ST_CLEAR;
        r_clr_idx <= '0;
        ovf <= 1'b0;
      end else if (w_sweep) begin
        r_clr_idx <= r_clr_idx + 1'b1;
        if (r_clr_idx == ADDR_W'(DEPTH-1)) r_state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_calc_mem_bank.sv
// tb_calc_mem_bank: randomized and directed checks of calc_mem_bank against an integer reference model
module tb_calc_mem_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, cmd_valid, cmd_ready, rvalid, ovf, busy;
  logic [2:0] cmd_op;
  logic [1:0] cmd_addr;
  logic [15:0] cmd_wdata, rdata;
  logic rst8, cmd_valid8, cmd_ready8, rvalid8, ovf8, busy8;
  logic [2:0] cmd_op8;
  logic [2:0] cmd_addr8;
  logic [15:0] cmd_wdata8, rdata8;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] m_mem [4];
  logic [15:0] m_rdata;
  logic m_ovf;
  calc_mem_bank dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rdata(rdata), .rvalid(rvalid), .ovf(ovf), .busy(busy)
  );
  calc_mem_bank #(.ADDR_W(3)) dut8 (
    .clk(clk), .rst(rst8), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8), .cmd_op(cmd_op8),
    .cmd_addr(cmd_addr8), .cmd_wdata(cmd_wdata8), .rdata(rdata8), .rvalid(rvalid8), .ovf(ovf8), .busy(busy8)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] m_acc(input logic [15:0] a, input logic [15:0] b, input bit sub, output bit of);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r = sub ? sa - sb : sa + sb;
    of = r > 32767 || r < -32768;
`ifdef CALC_MEM_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction
  task automatic do_cmd(input logic [2:0] op, input logic [1:0] a, input logic [15:0] d, output int waits);
    bit of;
    logic [15:0] r;
    waits = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_wdata = d;
    while (!cmd_ready && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 40) chk("ready_timeout", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    case (op)
      3'd1: m_mem[a] = d;
      3'd2: m_rdata = m_mem[a];
      3'd3, 3'd4: begin
        r = m_acc(m_mem[a], d, op == 3'd4, of);
        m_mem[a] = r;
        m_rdata = r;
        m_ovf = of;
      end
      3'd5: begin
        for (int i = 0; i < 4; i++) m_mem[i] = '0;
        m_ovf = 1'b0;
      end
      default: ;
    endcase
    chk($sformatf("rvalid_op%0d", op), rvalid, op inside {3'd2, 3'd3, 3'd4});
    chk($sformatf("rdata_op%0d", op), rdata, m_rdata);
    chk($sformatf("ovf_op%0d", op), ovf, m_ovf);
    chk("busy_vs_ready", busy, !cmd_ready);
  endtask
  task automatic cmd(input logic [2:0] op, input logic [1:0] a, input logic [15:0] d);
    int w;
    do_cmd(op, a, d, w);
  endtask
  task automatic cmd8(input logic [2:0] op, input logic [2:0] a, input logic [15:0] d);
    chk("ready8", cmd_ready8, 1);
    cmd_valid8 = 1'b1;
    cmd_op8 = op;
    cmd_addr8 = a;
    cmd_wdata8 = d;
    @(posedge clk); #1;
    cmd_valid8 = 1'b0;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int cnt, w;
    logic [2:0] op;
    logic [15:0] d;
    logic [15:0] pool [5];
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    rst8 = 1'b1; cmd_valid8 = 1'b0; cmd_op8 = '0; cmd_addr8 = '0; cmd_wdata8 = '0;
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    m_rdata = '0;
    m_ovf = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 1);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    rst8 = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("reset_busy_cycles", cnt, 4);
    for (int i = 0; i < 4; i++) cmd(3'd2, 2'(i), 16'h0);
    for (int i = 0; i < 4; i++) cmd(3'd1, 2'(i), 16'($urandom));
    for (int i = 0; i < 4; i++) cmd(3'd2, 2'(i), 16'h0);
    cmd(3'd1, 2'd1, 16'h0010);
    cmd(3'd3, 2'd1, 16'h0005);
    chk("acc_add", rdata, 16'h0015);
    cmd(3'd4, 2'd1, 16'h0020);
    chk("acc_sub", rdata, 16'hFFF5);
    chk("acc_ovf", ovf, 0);
    @(posedge clk); #1;
    chk("rvalid_one_cycle", rvalid, 0);
    cmd(3'd1, 2'd2, 16'h7FFF);
    cmd(3'd3, 2'd2, 16'h0001);
`ifdef CALC_MEM_SAT_EN
    chk("ovf_add_result", rdata, 16'h7FFF);
`else
    chk("ovf_add_result", rdata, 16'h8000);
`endif
    chk("ovf_add_flag", ovf, 1);
    cmd(3'd1, 2'd2, 16'h8000);
    cmd(3'd4, 2'd2, 16'h0001);
`ifdef CALC_MEM_SAT_EN
    chk("ovf_sub_result", rdata, 16'h8000);
`else
    chk("ovf_sub_result", rdata, 16'h7FFF);
`endif
    chk("ovf_sub_flag", ovf, 1);
    do_cmd(3'd5, 2'd0, 16'h0, w);
    do_cmd(3'd2, 2'd3, 16'h0, w);
    chk("clear_stall_cycles", w, 4);
    chk("clear_read", rdata, 0);
    chk("clear_ovf", ovf, 0);
    cmd(3'd1, 2'd0, 16'h1234);
    cmd(3'd2, 2'd0, 16'h0);
    chk("hazard_read", rdata, 16'h1234);
    cmd(3'd1, 2'd1, 16'h7FFF);
    cmd(3'd3, 2'd1, 16'h7FFF);
    cmd(3'd7, 2'd0, 16'($urandom));
    chk("op7_ovf_kept", ovf, 1);
    cmd(3'd2, 2'd0, 16'h0);
    chk("op7_mem_kept", rdata, 16'h1234);
    pool = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h0000};
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd5 && $urandom_range(0, 3) != 0) op = 3'd2;
      d = $urandom_range(0, 1) != 0 ? 16'($urandom) : pool[$urandom_range(0, 4)];
      cmd(op, 2'($urandom_range(0, 3)), d);
    end
    for (int i = 0; i < 8; i++) cmd8(3'd1, 3'(i), 16'(i + 1));
    cmd8(3'd2, 3'd7, 16'h0);
    chk("p8_read7", rdata8, 16'h0008);
    cmd8(3'd5, 3'd0, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("p8_midsweep_busy", busy8, 1);
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    cnt = 0;
    while (busy8 && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("p8_restart_busy_cycles", cnt, 8);
    for (int i = 0; i < 8; i++) begin
      cmd8(3'd2, 3'(i), 16'h0);
      chk($sformatf("p8_cleared_%0d", i), rdata8, 0);
      chk("p8_rvalid", rvalid8, 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
